// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader.
package loader_pkg;
    typedef enum logic [2:0] {SEND_REQ, RECV_SIZE, RECV_DATA, SEND_DONE, DONE} state_t;

    localparam logic [7:0] SYNC_REQ          = 8'h99;
    localparam logic [7:0] SYNC_DONE         = 8'hAA;
    localparam int         LOADER_SIZE_BYTES = 4;
endpackage

// File: rtl/byte_word_packer.sv
// Lane-indexed byte accumulator; word output already includes the byte being
// pushed this cycle and zero-fills lanes above it.
module byte_word_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  din,
    output logic [1:0]  lane,
    output logic [31:0] word
);
    logic [3:0][7:0] lanes_q;
    logic [1:0]      idx_q;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (push) begin
            lanes_q[idx_q] <= din;
            idx_q          <= idx_q + 2'd1;
        end
    end

    assign lane = idx_q;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign word[8*k +: 8] = (2'(k) < idx_q)           ? lanes_q[k] :
                                (2'(k) == idx_q && push)  ? din        : 8'h00;
    end
endmodule

// File: rtl/program_loader.sv
// Boot loader: requests a program over UART, writes it into instruction memory
// as little-endian words, then requests stdin and releases the core.
import loader_pkg::*;

module program_loader #(
    parameter int         IMEM_ADDR_W = 14,
    parameter logic [7:0] SYNC_REQ    = loader_pkg::SYNC_REQ,
    parameter logic [7:0] SYNC_DONE   = loader_pkg::SYNC_DONE
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [7:0]             rx_rdata,
    input  logic                   rx_rdata_ready,
    input  logic                   rx_ferr,
    output logic [7:0]             tx_sdata,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   imem_we,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    output logic [31:0]            imem_wdata,
    output logic                   load_done,
    output logic                   load_error
);
    state_t               state_q, state_d;
    logic [31:0]          bytes_left_q;
    logic [IMEM_ADDR_W:0] word_idx_q;
    logic                 tx_guard_q;

    logic        rx_ok, rx_bad, can_send;
    logic        tx_fire, size_load, data_byte, word_done, rx_err;
    logic [7:0]  tx_byte;
    logic        pk_push, pk_clear;
    logic [1:0]  pk_lane;
    logic [31:0] pk_word;

    assign rx_ok  = rx_rdata_ready && !rx_ferr;
    assign rx_bad = rx_rdata_ready && rx_ferr;
    // tx_busy only rises the cycle after tx_start, so block two cycles after a send
    assign can_send = !tx_busy && !tx_start && !tx_guard_q;

    byte_word_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (pk_clear),
        .push    (pk_push),
        .din     (rx_rdata),
        .lane    (pk_lane),
        .word    (pk_word)
    );

    always_comb begin
        state_d   = state_q;
        tx_fire   = 1'b0;
        tx_byte   = SYNC_REQ;
        pk_push   = 1'b0;
        pk_clear  = 1'b0;
        size_load = 1'b0;
        data_byte = 1'b0;
        word_done = 1'b0;
        rx_err    = 1'b0;
        case (state_q)
            SEND_REQ: if (can_send) begin
                tx_fire = 1'b1;
                state_d = RECV_SIZE;
            end
            RECV_SIZE: begin
                rx_err = rx_bad;
                if (rx_ok) begin
                    pk_push = 1'b1;
                    if (pk_lane == 2'(LOADER_SIZE_BYTES - 1)) begin
                        size_load = 1'b1;
                        state_d   = (pk_word == 32'd0) ? SEND_DONE : RECV_DATA;
                    end
                end
            end
            RECV_DATA: begin
                rx_err = rx_bad;
                if (rx_ok) begin
                    pk_push   = 1'b1;
                    data_byte = 1'b1;
                    word_done = (pk_lane == 2'd3) || (bytes_left_q == 32'd1);
                    if (bytes_left_q == 32'd1) begin
                        pk_clear = 1'b1;
                        state_d  = SEND_DONE;
                    end
                end
            end
            SEND_DONE: if (can_send) begin
                tx_fire = 1'b1;
                tx_byte = SYNC_DONE;
                state_d = DONE;
            end
            DONE:    ;
            default: state_d = SEND_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= SEND_REQ;
            bytes_left_q <= '0;
            word_idx_q   <= '0;
            tx_guard_q   <= 1'b0;
            tx_start     <= 1'b0;
            tx_sdata     <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            load_done    <= 1'b0;
            load_error   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_start   <= tx_fire;
            tx_guard_q <= tx_start;
            load_done  <= (state_d == DONE);
            imem_we    <= 1'b0;
            if (tx_fire)   tx_sdata <= tx_byte;
            if (size_load) bytes_left_q <= pk_word;
            if (data_byte) bytes_left_q <= bytes_left_q - 32'd1;
            if (rx_err)    load_error <= 1'b1;
            if (word_done) begin
                // top index bit set means memory is full; index saturates there
                if (word_idx_q[IMEM_ADDR_W]) begin
                    load_error <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= word_idx_q[IMEM_ADDR_W-1:0];
                    imem_wdata <= pk_word;
                    word_idx_q <= word_idx_q + (IMEM_ADDR_W+1)'(1);
                end
            end
        end
    end
endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- CPU-side boot loader; the counterpart of the host program/stdin sender on the same UART link.
- After reset it requests a program from the host by sending byte 0x99.
- It then receives a 4-byte little-endian program size and the program bytes, packs them into 32-bit little-endian words, and writes them into instruction memory.
- It then sends 0xAA to request stdin and asserts load_done, which releases the CPU core and hands the UART to the core.

Parameters:
- IMEM_ADDR_W, 14, instruction-memory word-address width; capacity = 2^IMEM_ADDR_W words.
- SYNC_REQ, 8'h99, byte sent to request the program.
- SYNC_DONE, 8'hAA, byte sent after the load completes (stdin request).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- rx_rdata  in  8  received byte from UART_RX.
- rx_rdata_ready  in  1  one-cycle strobe; rx_rdata is valid in this cycle.
- rx_ferr  in  1  framing error on the byte currently strobed.
- tx_sdata  out  8  byte to transmit to UART_TX.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  UART_TX busy.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  IMEM_ADDR_W  word address.
- imem_wdata  out  32  write data.
- load_done  out  1  level; high once loading is complete.
- load_error  out  1  sticky; set on framing error or capacity overflow.

Behaviour:
- Reset values: all outputs 0, state SEND_REQ, byte counters 0, size register 0.
- Reset mid-operation aborts the load immediately; the next load restarts at SEND_REQ.

Transmit handshake (used by SEND_REQ and SEND_DONE):
- tx_start is driven for exactly one cycle.
- It is issued only when tx_busy==0 and the guard flag is 0.
- The guard flag is set for one cycle after each tx_start, because tx_busy lags tx_start by one cycle.
- tx_sdata is registered in the same cycle as tx_start and held until the next transmission.

States:
- SEND_REQ: wait for the transmit handshake, then issue SYNC_REQ and go to RECV_SIZE. rx bytes arriving in this state are ignored.
- RECV_SIZE:
  - Collect 4 bytes, LSB first, into size[31:0].
  - On the 4th byte, if size==0 go to SEND_DONE; otherwise go to RECV_DATA.
- RECV_DATA:
  - Each byte shifts into word_buf at lane byte_idx[1:0], LSB first, and bytes_left decrements.
  - A write fires when lane 3 fills or bytes_left reaches 0:
    - imem_we=1 for one cycle, registered in the cycle after the completing rx_rdata_ready strobe.
    - imem_wdata = word_buf, with unfilled upper lanes set to 0 (size not a multiple of 4 is zero-padded).
    - imem_addr = word index, starting at 0 and incremented after each write.
  - After the final write, go to SEND_DONE.
- SEND_DONE: wait for the transmit handshake, issue SYNC_DONE, go to DONE.
- DONE: load_done=1 and stays 1 until reset. rx/tx ports are ignored; tx_start stays 0.

Boundary conditions:
- Framing error: a byte with rx_ferr=1 and rx_rdata_ready=1 is discarded (not counted) and load_error is set. The load continues with subsequent bytes.
- Capacity overflow: once the word index would exceed 2^IMEM_ADDR_W-1, further words are received and counted but not written (imem_we stays 0), and load_error is set. The load still completes and sends SYNC_DONE.
- At most one byte per cycle; rx_rdata_ready is never coincident with an internal write conflict, since writes are registered.
- Widths: size and bytes_left are 32-bit unsigned; word index is IMEM_ADDR_W+1 bits so overflow can be detected.

Decomposition:
- Package loader_pkg:
  - state enum {SEND_REQ, RECV_SIZE, RECV_DATA, SEND_DONE, DONE};
  - constants SYNC_REQ and SYNC_DONE;
  - LOADER_SIZE_BYTES=4.
- One sub-module, byte_word_packer: lane-indexed byte accumulator with clear, push, and flush (zero-pad). It is shared by the size and data phases.

Test Plan:
1. Reset release, tx_busy=0 -> tx_start pulses within 2 cycles with tx_sdata=0x99; exactly one pulse.
2. tx_busy held high for 100 cycles after reset -> no tx_start until the cycle after tx_busy falls; then 0x99 is sent.
3. Host sends 08 00 00 00, 01 02 03 04, 05 06 07 08 -> writes (0, 0x04030201) and (1, 0x08070605); then 0xAA is sent and load_done=1.
4. Size 06 00 00 00, data 11 22 33 44 55 66 -> writes (0, 0x44332211) and (1, 0x00006655); load_done=1.
5. Size 0 -> no imem_we; 0xAA is sent immediately after the size; load_done=1. Separately, IMEM_ADDR_W=1 with size 12 -> 2 writes, load_error=1, 0xAA is still sent.
6. Framing error on a data byte -> byte skipped, load_error=1. Separately, reset_n low mid-RECV_DATA -> outputs return to 0 and 0x99 is resent after release.
